// File: rtl/quant_ctrl_pkg.sv
// Shared types for the quantizer controller: FSM states, per-channel
// requantization parameters and the default quantizer latency.
package quant_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] M;
    logic [4:0]  n;
    logic        relu;
  } prm_t;

  localparam int unsigned QLAT_DEFAULT = 4;

endpackage

// File: rtl/quant_out_fifo.sv
// Synchronous output FIFO with occupancy count; head reads as zero when empty.
module quant_out_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop_eff, push_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A pop in the same cycle frees the slot, so push on full is legal then.
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/quant_ctrl.sv
// Layer controller feeding an external requantizer and buffering its results.
// Optional stall counter enabled by defining QUANT_CTRL_STALL_CNT_EN.
module quant_ctrl
  import quant_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CH     = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned QLAT       = QLAT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [8:0]                  cfg_num_ch,
  input  logic [15:0]                 cfg_num_pix,
  output logic                        busy,
  output logic                        done,
  input  logic                        prm_we,
  input  logic [$clog2(MAX_CH)-1:0]   prm_addr,
  input  logic [31:0]                 prm_M,
  input  logic [4:0]                  prm_n,
  input  logic                        prm_relu,
  input  logic signed [31:0]          acc_data,
  input  logic                        acc_valid,
  output logic                        acc_ready,
  output logic [31:0]                 q_data,
  output logic                        q_valid,
  output logic [31:0]                 q_M,
  output logic [4:0]                  q_n,
  output logic                        q_relu,
  input  logic [7:0]                  qo_data,
  input  logic                        qo_valid,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 stall_cycles
);

  localparam int unsigned AW = $clog2(MAX_CH);
  localparam int unsigned IW = $clog2(QLAT + 2);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_t        state, state_nxt;
  logic [8:0]    num_ch, ch_cnt;
  logic [15:0]   num_pix, pix_cnt;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  prm_t          prm_tbl [MAX_CH];
  prm_t          prm_rd;
  logic          start_ok, accept, last_ch, last_beat, qo_take;

  assign start_ok  = start && (state == IDLE);
  assign accept    = acc_valid && acc_ready;
  assign last_ch   = (ch_cnt == num_ch - 9'd1);
  assign last_beat = last_ch && (pix_cnt == num_pix - 16'd1);
  // Results returning while IDLE belong to an aborted layer and are dropped.
  assign qo_take   = qo_valid && (state != IDLE);
  assign prm_rd    = prm_tbl[ch_cnt[AW-1:0]];

  // RUN is only occupied while beats remain: the last accept leaves it.
  assign acc_ready = (state == RUN) &&
                     ((32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (prm_we && state == IDLE)
      prm_tbl[prm_addr] <= '{M: prm_M, n: prm_n, relu: prm_relu};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (cfg_num_ch == '0 || cfg_num_pix == '0) ? DONE : RUN;
      RUN:   if (accept && last_beat) state_nxt = DRAIN;
      DRAIN: if (inflight == '0 && fifo_empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_ch   <= '0;
      num_pix  <= '0;
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      inflight <= '0;
    end else if (start_ok) begin
      num_ch   <= cfg_num_ch;
      num_pix  <= cfg_num_pix;
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      inflight <= '0;
    end else begin
      if (accept) begin
        if (last_ch) begin
          ch_cnt <= '0;
          if (!last_beat) pix_cnt <= pix_cnt + 16'd1;
        end else begin
          ch_cnt <= ch_cnt + 9'd1;
        end
      end
      if (accept && !qo_take)
        inflight <= inflight + IW'(1);
      else if (!accept && qo_take && inflight != '0)
        inflight <= inflight - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_M     <= '0;
      q_n     <= '0;
      q_relu  <= 1'b0;
    end else begin
      q_valid <= accept;
      if (accept) begin
        q_data <= acc_data;
        q_M    <= prm_rd.M;
        q_n    <= prm_rd.n;
        q_relu <= prm_rd.relu;
      end
    end
  end

  quant_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (qo_take),
    .push_data (qo_data),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef QUANT_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_ok)
      stall_q <= '0;
    else if (state == RUN && acc_valid && !acc_ready && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
